bank_registers_mp: RTL and testbench
====================================

# bank_registers_mp

Parametrised multi-port MIPS register file, successor of the two-read/one-write bank. Provides N_READ synchronous read ports, N_WRITE prioritised write ports, a debug read port for the debug unit, and a post-reset clear sequencer that zeroes the array one entry per cycle. It sits in the ID stage, is written from WB, and is read by the debug/UART unit.

## Interface
- NB_REG, 5, register address width
- NB_DATA, 32, data width
- N_REGISTER, 32, number of registers; must equal 2**NB_REG
- N_READ, 2, read ports (1..4)
- N_WRITE, 2, write ports (1..2); a higher index has higher priority
- clock_i  in  1  clock; all logic is on posedge
- reset_i  in  1  reset; synchronous and active-high
- rw_i  in  N_WRITE  per-port write enable
- addr_rw_i  in  N_WRITE*NB_REG  write addresses, flattened; port k is in bits [k*NB_REG +: NB_REG]
- data_rw_i  in  N_WRITE*NB_DATA  write data, flattened in the same way
- addr_r_i  in  N_READ*NB_REG  read addresses, flattened
- data_r_o  out  N_READ*NB_DATA  registered read data, flattened
- dbg_addr_i  in  NB_REG  debug read address
- dbg_data_o  out  NB_DATA  registered debug read data
- busy_o  out  1  high while the clear sequence runs

## Operation
- FSM states:
  - CLEAR: reset_i=1 forces CLEAR with clr_idx=1. Each edge with reset_i=0 writes 0 to registers[clr_idx] and increments clr_idx. The edge that clears N_REGISTER-1 moves the FSM to RUN.
  - RUN: normal operation until the next reset.
- Register 0 is never written and always reads 0 on every port, including the debug port.
- Writes in RUN:
  - For each address, the highest-index port with rw_i set and a nonzero address wins.
  - Writes to address 0 are dropped.
- Writes in CLEAR are ignored and do not queue.
- Reads in RUN: data_r_o[j] is loaded with registers[addr_r_i[j]] on each edge. dbg_data_o is loaded the same way from dbg_addr_i.
- Reads in CLEAR: all read outputs load 0.
- Same-cycle read/write collision: behaviour depends on REGFILE_BYPASS_EN (see Configuration).

## Timing
- Reset values: data_r_o=0, dbg_data_o=0, busy_o=1.
- Read latency is 1 cycle, from address at edge t to data valid after edge t.
- Write latency is 1 cycle. A read issued on the edge after the write returns the new value in both build modes.
- busy_o stays high from reset through the edge that clears register N_REGISTER-1. With N_REGISTER=32, busy_o is high for exactly 31 edges after reset deasserts, then falls.
- Reset asserted mid-CLEAR or mid-RUN restarts CLEAR at clr_idx=1. Registers not yet re-cleared keep their old values but are unreadable until RUN.
- Two write ports hitting the same address: the port with the higher index wins, and bypass returns that port's data.
- Reset has priority over every write and over the clear step in the same cycle.

## Configuration
- REGFILE_BYPASS_EN defined: a read (including the debug port) whose address matches a winning nonzero write in the same cycle returns the write data.
- REGFILE_BYPASS_EN undefined: that read returns the pre-write array contents. The ID-stage forwarding unit covers the hazard.

## Structure
- Shared package regfile_pkg holds:
  - localparams for the default NB_REG, NB_DATA and N_REGISTER
  - the FSM state encoding (CLEAR=1'b0, RUN=1'b1)
  - a write-priority resolve function
- One sub-module: regfile_clear_seq, which contains the FSM and clr_idx counter and drives busy_o, clr_en and clr_addr. The array, write mux and read ports stay in the top module.

## Test plan
- Reset for 3 cycles, then release -> busy_o is 1 for 31 edges and then 0; every read port returns 0 during CLEAR; writing 0xDEADBEEF to reg 5 during CLEAR, then reading reg 5 in RUN -> 0.
- RUN: write 0x12345678 to reg 7 on port 0, read reg 7 on all ports on the next edge -> 0x12345678. Write 0xFFFFFFFF to reg 0, then read reg 0 -> 0.
- Port 0 writes 0xAAAA0000 and port 1 writes 0x0000BBBB to reg 9 in the same cycle -> reg 9 reads 0x0000BBBB.
- Same-cycle write of 0x55 to reg 3 with a read of reg 3, where reg 3 previously held 0x11 -> read returns 0x55 with REGFILE_BYPASS_EN, 0x11 without. The next-cycle read returns 0x55 in both builds.
- Assert reset at clear edge 10 and then release -> busy_o stays high for a further 31 edges.
- Set dbg_addr_i=7 after the reg 7 write -> dbg_data_o is 0x12345678 one cycle later; normal read ports are unaffected.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared definitions for the multi-port MIPS register file:
//                default geometry, clear-sequencer state encoding and the
//                write-port priority resolver.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int C_NB_REG      = 5;
    localparam int C_NB_DATA     = 32;
    localparam int C_N_REGISTER  = 32;

    // Upper bound on write ports the resolver can arbitrate between.
    localparam int C_MAX_WRITE   = 4;

    // Clear-sequencer state encoding.
    localparam logic [0:0] C_ST_CLEAR = 1'b0;
    localparam logic [0:0] C_ST_RUN   = 1'b1;

    // Picks the highest-index requesting write port.
    // Returns {hit, port_index}; hit is 0 when nobody requests.
    function automatic logic [2:0] resolve_write(input logic [C_MAX_WRITE-1:0] req);
        logic [2:0] w_res;
        w_res = 3'b000;
        for (int k = 0; k < C_MAX_WRITE; k++) begin
            if (req[k]) begin
                w_res = {1'b1, 2'(k)};
            end
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_clear_seq
//  Description : Post-reset clear sequencer. After reset releases it walks
//                registers 1..N_REGISTER-1, one per clock, requesting a zero
//                write for each, then enters RUN until the next reset.
//  Ports       : clock_i    - clock (posedge)
//                reset_i    - synchronous active-high reset
//                busy_o     - high while in CLEAR
//                run_o      - high in RUN (normal operation)
//                clr_en_o   - zero-write request for clr_addr_o this cycle
//                clr_addr_o - register currently being cleared
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NB_REG     = C_NB_REG,
    parameter int N_REGISTER = C_N_REGISTER
) (
    input  logic              clock_i,
    input  logic              reset_i,
    output logic              busy_o,
    output logic              run_o,
    output logic              clr_en_o,
    output logic [NB_REG-1:0] clr_addr_o
);

    localparam logic [NB_REG-1:0] C_LAST_IDX = NB_REG'(N_REGISTER - 1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [NB_REG-1:0] r_clr_idx;

    // State register and clear index. Register 0 is hard-wired, so the walk
    // starts at 1.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state   <= C_ST_CLEAR;
            r_clr_idx <= NB_REG'(1);
        end else begin
            r_state <= w_state_next;
            if (r_state == C_ST_CLEAR) begin
                r_clr_idx <= r_clr_idx + NB_REG'(1);
            end
        end
    end

    // Next-state logic: the edge that clears the last register enters RUN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_CLEAR: begin
                if (r_clr_idx == C_LAST_IDX) begin
                    w_state_next = C_ST_RUN;
                end
            end
            C_ST_RUN: begin
                w_state_next = C_ST_RUN;
            end
            default: begin
                w_state_next = C_ST_CLEAR;
            end
        endcase
    end

    // Outputs. Reset suppresses the clear write of the same cycle.
    always_comb begin
        busy_o     = (r_state == C_ST_CLEAR);
        run_o      = (r_state == C_ST_RUN);
        clr_en_o   = (r_state == C_ST_CLEAR) && !reset_i;
        clr_addr_o = r_clr_idx;
    end

endmodule
`default_nettype wire

// File: rtl/bank_registers_mp.sv
`default_nettype none
// ============================================================================
//  Module      : bank_registers_mp
//  Description : Parametrised multi-port MIPS register file. N_READ registered
//                read ports, N_WRITE prioritised write ports (higher index
//                wins), a registered debug read port, and a post-reset clear
//                sequence that zeroes one register per cycle.
//                Optional macro REGFILE_BYPASS_EN: a read whose address
//                matches a winning write in the same cycle returns the write
//                data instead of the old array contents.
//  Ports       : clock_i, reset_i  - clock / synchronous active-high reset
//                rw_i, addr_rw_i, data_rw_i - write enables, addresses, data
//                addr_r_i, data_r_o         - read addresses, registered data
//                dbg_addr_i, dbg_data_o     - debug read address / data
//                busy_o                     - clear sequence in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module bank_registers_mp
    import regfile_pkg::*;
#(
    parameter int NB_REG     = C_NB_REG,
    parameter int NB_DATA    = C_NB_DATA,
    parameter int N_REGISTER = C_N_REGISTER,
    parameter int N_READ     = 2,
    parameter int N_WRITE    = 2
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic [N_WRITE-1:0]         rw_i,
    input  logic [N_WRITE*NB_REG-1:0]  addr_rw_i,
    input  logic [N_WRITE*NB_DATA-1:0] data_rw_i,
    input  logic [N_READ*NB_REG-1:0]   addr_r_i,
    output logic [N_READ*NB_DATA-1:0]  data_r_o,
    input  logic [NB_REG-1:0]          dbg_addr_i,
    output logic [NB_DATA-1:0]         dbg_data_o,
    output logic                       busy_o
);

    logic                                w_run;
    logic                                w_clr_en;
    logic [NB_REG-1:0]                   w_clr_addr;
    logic                                w_wr_active;

    logic [NB_DATA-1:0]                  r_regs [N_REGISTER];
    logic [N_REGISTER-1:0]               w_wr_hit;
    logic [N_REGISTER-1:0][NB_DATA-1:0]  w_wr_data;

    // Read ports 0..N_READ-1 followed by the debug port at index N_READ.
    logic [N_READ:0][NB_REG-1:0]         w_rd_addr;
    logic [N_READ:0][NB_DATA-1:0]        w_rd_val;
    logic [N_READ:0][NB_DATA-1:0]        r_rd_data;
`ifdef REGFILE_BYPASS_EN
    logic [NB_DATA:0]                    w_rd_lookup;
`endif

    regfile_clear_seq #(
        .NB_REG     (NB_REG),
        .N_REGISTER (N_REGISTER)
    ) u_clear_seq (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .busy_o     (busy_o),
        .run_o      (w_run),
        .clr_en_o   (w_clr_en),
        .clr_addr_o (w_clr_addr)
    );

    // Writes only land in RUN and never in a reset cycle.
    assign w_wr_active = w_run && !reset_i;

    // Winning write for address a this cycle: {hit, data}. Address 0 never
    // hits, so register 0 stays constant and is never bypassed.
    function automatic logic [NB_DATA:0] write_lookup(input logic [NB_REG-1:0] a);
        logic [C_MAX_WRITE-1:0] w_req;
        logic [2:0]             w_win;
        logic [NB_DATA-1:0]     w_dat;
        w_req = '0;
        w_dat = '0;
        for (int k = 0; k < N_WRITE; k++) begin
            w_req[k] = w_wr_active && rw_i[k] && (a != '0)
                       && (addr_rw_i[k*NB_REG +: NB_REG] == a);
        end
        w_win = resolve_write(w_req);
        for (int k = 0; k < N_WRITE; k++) begin
            if (w_win[1:0] == 2'(k)) begin
                w_dat = data_rw_i[k*NB_DATA +: NB_DATA];
            end
        end
        return {w_win[2], w_dat};
    endfunction

    // Per-register write decode.
    always_comb begin
        w_wr_hit  = '0;
        w_wr_data = '0;
        for (int r = 0; r < N_REGISTER; r++) begin
            {w_wr_hit[r], w_wr_data[r]} = write_lookup(NB_REG'(r));
        end
    end

    // Register array. Not reset: the clear sequencer zeroes it, and contents
    // left over from an interrupted clear stay hidden behind the CLEAR read
    // gating below.
    always_ff @(posedge clock_i) begin
        if (w_clr_en) begin
            r_regs[w_clr_addr] <= '0;
        end else begin
            for (int r = 0; r < N_REGISTER; r++) begin
                if (w_wr_hit[r]) begin
                    r_regs[r] <= w_wr_data[r];
                end
            end
        end
    end

    assign w_rd_addr = {dbg_addr_i, addr_r_i};

    // Read value selection, shared by normal and debug ports.
    always_comb begin
        w_rd_val = '0;
`ifdef REGFILE_BYPASS_EN
        w_rd_lookup = '0;
`endif
        for (int j = 0; j <= N_READ; j++) begin
            if (w_rd_addr[j] != '0) begin
                w_rd_val[j] = r_regs[w_rd_addr[j]];
`ifdef REGFILE_BYPASS_EN
                w_rd_lookup = write_lookup(w_rd_addr[j]);
                if (w_rd_lookup[NB_DATA]) begin
                    w_rd_val[j] = w_rd_lookup[NB_DATA-1:0];
                end
`endif
            end
        end
    end

    // Output registers load zero through reset and the whole clear sequence.
    always_ff @(posedge clock_i) begin
        if (reset_i || !w_run) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_val;
        end
    end

    assign data_r_o   = r_rd_data[N_READ-1:0];
    assign dbg_data_o = r_rd_data[N_READ];

endmodule
`default_nettype wire

// File: tb/tb_bank_registers_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bank_registers_mp
//  Description : Self-checking bench for bank_registers_mp. Expected read
//                results are queued when the read address is driven and
//                compared one edge later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_registers_mp;

    localparam int N_READ  = 2;
    localparam int N_WRITE = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit C_BYPASS = 1'b1;
`else
    localparam bit C_BYPASS = 1'b0;
`endif

    logic                  clock_i = 1'b0;
    logic                  reset_i;
    logic [N_WRITE-1:0]    rw_i;
    logic [N_WRITE*5-1:0]  addr_rw_i;
    logic [N_WRITE*32-1:0] data_rw_i;
    logic [N_READ*5-1:0]   addr_r_i;
    logic [N_READ*32-1:0]  data_r_o;
    logic [4:0]            dbg_addr_i;
    logic [31:0]           dbg_data_o;
    logic                  busy_o;

    typedef struct {
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bank_registers_mp #(
        .NB_REG     (5),
        .NB_DATA    (32),
        .N_REGISTER (32),
        .N_READ     (N_READ),
        .N_WRITE    (N_WRITE)
    ) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .rw_i       (rw_i),
        .addr_rw_i  (addr_rw_i),
        .data_rw_i  (data_rw_i),
        .addr_r_i   (addr_r_i),
        .data_r_o   (data_r_o),
        .dbg_addr_i (dbg_addr_i),
        .dbg_data_o (dbg_data_o),
        .busy_o     (busy_o)
    );

    always #5 clock_i = ~clock_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] observed(input int p);
        if (p < N_READ) return data_r_o[p*32 +: 32];
        return dbg_data_o;
    endfunction

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle_writes();
        rw_i      = '0;
        addr_rw_i = '0;
        data_rw_i = '0;
    endtask

    task automatic set_write(input int port, input logic [4:0] a, input logic [31:0] d);
        rw_i[port]               = 1'b1;
        addr_rw_i[port*5 +: 5]   = a;
        data_rw_i[port*32 +: 32] = d;
    endtask

    task automatic set_reads(input logic [4:0] a);
        for (int j = 0; j < N_READ; j++) addr_r_i[j*5 +: 5] = a;
        dbg_addr_i = a;
    endtask

    task automatic expect_reads(input logic [31:0] v);
        exp_t x;
        for (int j = 0; j <= N_READ; j++) begin
            x.port = j;
            x.val  = v;
            sb.push_back(x);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        reset_i = 1'b1;
        idle_writes();
        for (int c = 0; c < 3; c++) begin
            set_reads(5'd5);
            expect_reads(32'h0);
            tick();
            n_checks++;
            if (busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_busy: got %b required 1", busy_o);
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (observed(e.port) !== e.val) begin
                    n_fail++;
                    $display("FAIL reset_read port %0d: got %h required %h", e.port, observed(e.port), e.val);
                end
            end
        end
    endtask

    task automatic test_clear();
        exp_t e;
        reset_i = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            idle_writes();
            // Edge 10 comes after register 5 was cleared, so a leaked write
            // would still be visible once RUN starts.
            if (c == 10) set_write(0, 5'd5, 32'hDEADBEEF);
            set_reads(5'd5);
            expect_reads(32'h0);
            tick();
            if (c <= 31) begin
                n_checks++;
                if (busy_o !== (c < 31)) begin
                    n_fail++;
                    $display("FAIL clear_busy edge %0d: got %b required %b", c, busy_o, (c < 31));
                end
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (observed(e.port) !== e.val) begin
                    n_fail++;
                    $display("FAIL clear_read edge %0d port %0d: got %h required %h", c, e.port, observed(e.port), e.val);
                end
            end
        end
    endtask

    // One cycle of stimulus: reads of ra, expected value ev, then compare.
    task automatic test_write_read();
        exp_t e;
        logic [4:0]  ra [4];
        logic [31:0] ev [4];
        ra = '{5'd0, 5'd7, 5'd0, 5'd0};
        ev = '{32'h0, 32'h12345678, 32'h0, 32'h0};
        for (int c = 0; c < 4; c++) begin
            idle_writes();
            if (c == 0) set_write(0, 5'd7, 32'h12345678);
            if (c == 2) set_write(1, 5'd0, 32'hFFFFFFFF);
            if (c == 3) set_write(0, 5'd0, 32'hFFFFFFFF);
            set_reads(ra[c]);
            expect_reads(ev[c]);
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (observed(e.port) !== e.val) begin
                    n_fail++;
                    $display("FAIL write_read step %0d port %0d: got %h required %h", c, e.port, observed(e.port), e.val);
                end
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        logic [4:0]  ra [6];
        logic [31:0] ev [6];
        ra = '{5'd7, 5'd9, 5'd7, 5'd9, 5'd7, 5'd9};
        ev = '{32'h12345678, 32'h0000BBBB, 32'h12345678, 32'hCAFE0001,
               32'h12345678, 32'h00001111};
        for (int c = 0; c < 6; c++) begin
            idle_writes();
            if (c == 0) begin
                set_write(0, 5'd9, 32'hAAAA0000);
                set_write(1, 5'd9, 32'h0000BBBB);
            end
            if (c == 2) begin
                // Higher port aims at register 0, so port 0 must win.
                set_write(0, 5'd9, 32'hCAFE0001);
                set_write(1, 5'd0, 32'h00000077);
            end
            if (c == 4) begin
                // Higher port has a matching address but no enable.
                set_write(0, 5'd9, 32'h00001111);
                addr_rw_i[5 +: 5]  = 5'd9;
                data_rw_i[32 +: 32] = 32'h00002222;
            end
            set_reads(ra[c]);
            expect_reads(ev[c]);
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (observed(e.port) !== e.val) begin
                    n_fail++;
                    $display("FAIL priority step %0d port %0d: got %h required %h", c, e.port, observed(e.port), e.val);
                end
            end
        end
    endtask

    task automatic test_collision();
        exp_t e;
        logic [4:0]  ra [5];
        logic [31:0] ev [5];
        ra = '{5'd7, 5'd3, 5'd3, 5'd12, 5'd12};
        ev = '{32'h12345678, (C_BYPASS ? 32'h55 : 32'h11), 32'h55,
               (C_BYPASS ? 32'h0000000B : 32'h0), 32'h0000000B};
        for (int c = 0; c < 5; c++) begin
            idle_writes();
            if (c == 0) set_write(0, 5'd3, 32'h11);
            if (c == 1) set_write(0, 5'd3, 32'h55);
            if (c == 3) begin
                set_write(0, 5'd12, 32'h0000000A);
                set_write(1, 5'd12, 32'h0000000B);
            end
            set_reads(ra[c]);
            expect_reads(ev[c]);
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (observed(e.port) !== e.val) begin
                    n_fail++;
                    $display("FAIL collision step %0d port %0d: got %h required %h", c, e.port, observed(e.port), e.val);
                end
            end
        end
    endtask

    task automatic test_debug();
        exp_t e;
        exp_t x;
        idle_writes();
        set_reads(5'd3);
        dbg_addr_i = 5'd7;
        for (int j = 0; j < N_READ; j++) begin
            x.port = j;
            x.val  = 32'h55;
            sb.push_back(x);
        end
        x.port = N_READ;
        x.val  = 32'h12345678;
        sb.push_back(x);
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (observed(e.port) !== e.val) begin
                n_fail++;
                $display("FAIL debug port %0d: got %h required %h", e.port, observed(e.port), e.val);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        exp_t e;
        int   edges;
        idle_writes();
        // Reset out of RUN, then let 10 clear edges pass. Register 12 still
        // holds 0xB but must read as zero.
        reset_i = 1'b1;
        set_reads(5'd12);
        tick();
        reset_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            set_reads(5'd12);
            expect_reads(32'h0);
            tick();
            n_checks++;
            if (busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL midclear_busy edge %0d: got %b required 1", c, busy_o);
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (observed(e.port) !== e.val) begin
                    n_fail++;
                    $display("FAIL midclear_read edge %0d port %0d: got %h required %h", c, e.port, observed(e.port), e.val);
                end
            end
        end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        edges = 0;
        do begin
            set_reads(5'd12);
            expect_reads(32'h0);
            tick();
            edges++;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (observed(e.port) !== e.val) begin
                    n_fail++;
                    $display("FAIL restart_read edge %0d port %0d: got %h required %h", edges, e.port, observed(e.port), e.val);
                end
            end
        end while (busy_o === 1'b1 && edges < 40);
        n_checks++;
        if (edges != 31) begin
            n_fail++;
            $display("FAIL restart_busy_edges: got %0d required 31", edges);
        end
        // Register 12 was re-cleared by the restarted sequence.
        set_reads(5'd12);
        expect_reads(32'h0);
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (observed(e.port) !== e.val) begin
                n_fail++;
                $display("FAIL recleared port %0d: got %h required %h", e.port, observed(e.port), e.val);
            end
        end
    endtask

    initial begin
        reset_i    = 1'b1;
        rw_i       = '0;
        addr_rw_i  = '0;
        data_rw_i  = '0;
        addr_r_i   = '0;
        dbg_addr_i = '0;
        #2;
        test_reset();
        test_clear();
        test_write_read();
        test_priority();
        test_collision();
        test_debug();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
